canny_window_driver: RTL
========================

Name:
canny_window_driver

Overview:
- Host-side initiator for the 5x5 Canny edge core's register/strobe interface.
- Takes a row-major pixel stream over a valid/ready handshake and writes the 25 pixels into the core's selected window register.
- Then holds the operation enable low for a fixed number of cycles in the requested mode, reads one result byte back, and presents it as a one-cycle result pulse.
- Replaces bench-driven sequencing so a pixel pipeline can drive the core directly.

Parameters:
- DATA_WIDTH, 8, pixel/result width.
- OP_CYCLES, 4, cycles core_bOPEnable is held low per operation (range 1..255).
- READ_ROW, 1, row address driven during the result read.
- READ_COL, 1, column address driven during the result read.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- op_mode  in  3  operation mode for the core; captured on start.
- write_sel  in  4  target window register (0=X, 1=Y, other=Z); captured on start.
- read_sel  in  4  result source register (0..4); captured on start.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  DATA_WIDTH  pixel stream data.
- pix_ready  out  1  pixel stream ready.
- core_row  out  3  core row address.
- core_col  out  3  core column address.
- core_bCE  out  1  core chip enable, active low.
- core_bWE  out  1  core write enable, active low.
- core_InData  out  DATA_WIDTH  core write data.
- core_OPMode  out  3  core operation mode.
- core_bOPEnable  out  1  core operation enable, active low.
- core_dReadReg  out  4  core read select.
- core_dWriteReg  out  4  core write select.
- core_OutData  in  DATA_WIDTH  core read data; valid the cycle after a read strobe.
- busy  out  1  job in progress.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  DATA_WIDTH  result byte; holds until the next capture.

Behaviour:
- All core_* outputs, busy, res_valid and res_data are registered. pix_ready is combinational from state and count.
- Reset (async, any state): state=IDLE; count, row, col=0; core_bCE=1, core_bWE=1, core_bOPEnable=1; core_row, core_col, core_InData, core_OPMode, core_dReadReg, core_dWriteReg=0; busy=0; res_valid=0; res_data=0; pix_ready=0.
- States: IDLE, LOAD, OP, READ, CAPTURE.
- IDLE:
  - start=1 captures op_mode, write_sel and read_sel, clears count/row/col, sets busy=1 and moves to LOAD.
  - start is ignored while busy=1.
- LOAD:
  - pix_ready=1 while count<25.
  - On each accept (pix_valid & pix_ready), the next cycle drives core_bCE=0, core_bWE=0, core_row/core_col = current row/col, core_InData=pix_data, core_dWriteReg=captured write_sel. All other cycles drive bCE=bWE=1.
  - col counts 0..4; at 4 it wraps to 0 and row increments. count increments per accept.
  - Stalls on pix_valid=0 insert idle cycles with no write strobe; the address does not advance.
  - After the 25th accept: pix_ready=0 from the next cycle; the final write strobe completes; the state enters OP on the edge that ends that strobe.
- OP:
  - core_bOPEnable=0, core_OPMode=captured op_mode, bCE=bWE=1 for exactly OP_CYCLES cycles (internal down-counter).
  - Then moves to READ.
- READ (1 cycle):
  - core_bOPEnable=1, core_bCE=0, core_bWE=1.
  - core_row=READ_ROW, core_col=READ_COL, core_dReadReg=captured read_sel.
- CAPTURE (1 cycle):
  - core strobes deasserted.
  - At the ending edge: res_data<=core_OutData, res_valid<=1, busy<=0; moves to IDLE.
- res_valid is high exactly one cycle, the first IDLE cycle. A start in that same cycle is accepted.
- Latency with pix_valid held high: start sampled at edge 0 → accepts at edges 1..25 → OP from edge 26 → res_valid high after edge 26+OP_CYCLES+2 (edge 32 at default).
- op_mode values >3 are passed through unchanged; the driver does not check them.
- Write and op strobes are never asserted in the same cycle. The strobes bCE=0 and bOPEnable=0 are mutually exclusive.

Test Plan:
- Continuous stream 1..25, write_sel=0, OP_CYCLES=4 → bench core model records 25 writes with addr (r,c) = (i/5, i%5) and data i+1, in order. Then 4 cycles of bOPEnable=0, then one read at (1,1). res_valid after edge 32.
- pix_valid toggled every other cycle → same 25 address/data pairs, no duplicate or skipped writes, pix_ready low after the 25th accept.
- Core model returns 0xA5 on read with read_sel=3 → res_data=0xA5 and a single-cycle res_valid. res_data still 0xA5 ten cycles later.
- start pulsed during LOAD and OP → ignored; captured op_mode and write_sel unchanged; exactly one res_valid.
- rst_b low mid-LOAD after 12 accepts → outputs at reset values immediately. A new job then writes from address (0,0).
- start asserted in the res_valid cycle → a new job begins; busy returns high the next cycle.

Source files
------------

// File: rtl/canny_window_driver.sv
// canny_window_driver: streams 25 pixels into a Canny core window, runs one op, reads back one result byte
module canny_window_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_CYCLES  = 4,
  parameter int READ_ROW   = 1,
  parameter int READ_COL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic [2:0]            op_mode,
  input  logic [3:0]            write_sel,
  input  logic [3:0]            read_sel,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic [2:0]            core_row,
  output logic [2:0]            core_col,
  output logic                  core_bCE,
  output logic                  core_bWE,
  output logic [DATA_WIDTH-1:0] core_InData,
  output logic [2:0]            core_OPMode,
  output logic                  core_bOPEnable,
  output logic [3:0]            core_dReadReg,
  output logic [3:0]            core_dWriteReg,
  input  logic [DATA_WIDTH-1:0] core_OutData,
  output logic                  busy,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data
);
  typedef enum logic [2:0] {IDLE, LOAD, OP, READ, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [2:0] row_q, row_d, col_q, col_d, mode_q, mode_d;
  logic [7:0] opcnt_q, opcnt_d;
  logic [3:0] wsel_q, wsel_d, rsel_q, rsel_d;
  logic [2:0] crow_q, crow_d, ccol_q, ccol_d, opm_q, opm_d;
  logic bce_q, bce_d, bwe_q, bwe_d, bop_q, bop_d, busy_q, busy_d, rv_q, rv_d;
  logic [DATA_WIDTH-1:0] ind_q, ind_d, rd_q, rd_d;
  logic [3:0] drd_q, drd_d, dwr_q, dwr_d;
  logic accept;
  assign pix_ready = (state_q == LOAD) && (count_q < 5'd25);
  assign accept = pix_valid && pix_ready;
  assign core_row = crow_q;
  assign core_col = ccol_q;
  assign core_bCE = bce_q;
  assign core_bWE = bwe_q;
  assign core_InData = ind_q;
  assign core_OPMode = opm_q;
  assign core_bOPEnable = bop_q;
  assign core_dReadReg = drd_q;
  assign core_dWriteReg = dwr_q;
  assign busy = busy_q;
  assign res_valid = rv_q;
  assign res_data = rd_q;
  // Next state, counters and the registered core-side strobes derived from the upcoming state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    row_d = row_q;
    col_d = col_q;
    opcnt_d = opcnt_q;
    mode_d = mode_q;
    wsel_d = wsel_q;
    rsel_d = rsel_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        mode_d = op_mode;
        wsel_d = write_sel;
        rsel_d = read_sel;
        count_d = '0;
        row_d = '0;
        col_d = '0;
      end
      LOAD: if (accept) begin
        count_d = count_q + 5'd1;
        col_d = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
        row_d = (col_q == 3'd4) ? row_q + 3'd1 : row_q;
      end else if (count_q == 5'd25) begin
        state_d = OP;
        opcnt_d = 8'(OP_CYCLES - 1);
      end
      OP: if (opcnt_q == 8'd0) state_d = READ;
          else opcnt_d = opcnt_q - 8'd1;
      READ: state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bce_d = !(accept || state_d == READ);
    bwe_d = !accept;
    bop_d = state_d != OP;
    crow_d = accept ? row_q : (state_d == READ) ? 3'(READ_ROW) : crow_q;
    ccol_d = accept ? col_q : (state_d == READ) ? 3'(READ_COL) : ccol_q;
    ind_d = accept ? pix_data : ind_q;
    dwr_d = accept ? wsel_q : dwr_q;
    opm_d = (state_d == OP) ? mode_q : opm_q;
    drd_d = (state_d == READ) ? rsel_q : drd_q;
    busy_d = state_d != IDLE;
    rv_d = state_q == CAPTURE;
    rd_d = (state_q == CAPTURE) ? core_OutData : rd_q;
  end
  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      count_q <= '0;
      row_q <= '0;
      col_q <= '0;
      opcnt_q <= '0;
      mode_q <= '0;
      wsel_q <= '0;
      rsel_q <= '0;
      crow_q <= '0;
      ccol_q <= '0;
      opm_q <= '0;
      bce_q <= 1'b1;
      bwe_q <= 1'b1;
      bop_q <= 1'b1;
      busy_q <= 1'b0;
      rv_q <= 1'b0;
      ind_q <= '0;
      rd_q <= '0;
      drd_q <= '0;
      dwr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      row_q <= row_d;
      col_q <= col_d;
      opcnt_q <= opcnt_d;
      mode_q <= mode_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      crow_q <= crow_d;
      ccol_q <= ccol_d;
      opm_q <= opm_d;
      bce_q <= bce_d;
      bwe_q <= bwe_d;
      bop_q <= bop_d;
      busy_q <= busy_d;
      rv_q <= rv_d;
      ind_q <= ind_d;
      rd_q <= rd_d;
      drd_q <= drd_d;
      dwr_q <= dwr_d;
    end
  end
endmodule
